// File: rtl/fifo_readout_if.sv
// ============================================================================
//  Module   : fifo_readout_if
//  Purpose  : Pop handshake and FIFO control signals of the event-FIFO
//             readout path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_readout_if #(
    parameter int AWIDTH = 12
);
    logic              pop_req;
    logic              pop_ack;
    logic              pop_empty;
    logic              fifo_rd_en;
    logic              fifo_rst_n;
    logic [AWIDTH-1:0] fifo_numel;

    // Requester / FIFO side
    modport master (
        output pop_req,
        output fifo_numel,
        input  pop_ack,
        input  pop_empty,
        input  fifo_rd_en,
        input  fifo_rst_n
    );

    // Controller side
    modport slave (
        input  pop_req,
        input  fifo_numel,
        output pop_ack,
        output pop_empty,
        output fifo_rd_en,
        output fifo_rst_n
    );
endinterface

`default_nettype wire

// File: rtl/fifo_readout_ctrl.sv
// ============================================================================
//  Module   : fifo_readout_ctrl
//  Purpose  : Event-FIFO controller: reset sequencing, pop serialisation,
//             hysteretic IRQ, high-water mark and sticky underflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_readout_ctrl #(
    parameter int AWIDTH     = 12,
    parameter int RST_CYCLES = 4,
    parameter int RD_LAT     = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    fifo_readout_if.slave          bus,
    input  wire logic [AWIDTH-1:0] irq_assert_thresh,
    input  wire logic [AWIDTH-1:0] irq_deassert_thresh,
    input  wire logic              sw_fifo_rst,
    input  wire logic              clr_flags,
    output logic                   irq,
    output logic                   underflow,
    output logic [AWIDTH-1:0]      hwm,
    output logic                   busy
);

    localparam int c_CNT_MAX = (RST_CYCLES > RD_LAT) ? RST_CYCLES : RD_LAT;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CW-1:0] c_RST_LOAD  = c_CW'(RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_WAIT_LOAD = c_CW'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    typedef enum logic [2:0] {
        S_RST_HOLD = 3'd0,
        S_IDLE     = 3'd1,
        S_POP      = 3'd2,
        S_WAIT     = 3'd3,
        S_ACK      = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_rst_pend, w_rst_pend_nxt;
    logic              w_uflow_set, w_pop_empty_nxt, w_hwm_clr;
    logic              w_irq_cfg_ok, w_irq_nxt;

    logic              r_pop_ack, r_pop_empty, r_rd_en, r_fifo_rst_n;
    logic              r_irq, r_underflow, r_busy;
    logic [AWIDTH-1:0] r_hwm;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rst_pend_nxt  = r_rst_pend;
        w_uflow_set     = 1'b0;
        w_pop_empty_nxt = 1'b0;
        w_hwm_clr       = 1'b0;

        case (r_state)
            S_RST_HOLD: begin
                if (sw_fifo_rst) begin
                    w_cnt_nxt = c_RST_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_hwm_clr   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_IDLE: begin
                if (sw_fifo_rst) begin
                    w_state_nxt = S_RST_HOLD;
                    w_cnt_nxt   = c_RST_LOAD;
                end else if (bus.pop_req) begin
                    if (bus.fifo_numel != '0) begin
                        w_state_nxt = S_POP;
                    end else begin
                        w_state_nxt     = S_ACK;
                        w_pop_empty_nxt = 1'b1;
                        w_uflow_set     = 1'b1;
                    end
                end
            end
            S_POP: begin
                w_rst_pend_nxt = r_rst_pend | sw_fifo_rst;
                if (RD_LAT <= 1) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_WAIT_LOAD;
                end
            end
            S_WAIT: begin
                w_rst_pend_nxt = r_rst_pend | sw_fifo_rst;
                if (r_cnt == '0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ACK: begin
                // A reset request in the ack cycle itself must not be lost
                if (r_rst_pend || sw_fifo_rst) begin
                    w_state_nxt = S_RST_HOLD;
                    w_cnt_nxt   = c_RST_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_RST_HOLD;
                w_cnt_nxt   = c_RST_LOAD;
            end
        endcase

        if (w_state_nxt == S_RST_HOLD) begin
            w_rst_pend_nxt = 1'b0;
        end
    end

    always_comb begin
        w_irq_cfg_ok = (irq_assert_thresh != '0) && (irq_deassert_thresh < irq_assert_thresh);
        w_irq_nxt    = r_irq;
        if ((r_state == S_RST_HOLD) || !w_irq_cfg_ok) begin
            w_irq_nxt = 1'b0;
        end else if (!r_irq && (bus.fifo_numel >= irq_assert_thresh)) begin
            w_irq_nxt = 1'b1;
        end else if (r_irq && (bus.fifo_numel <= irq_deassert_thresh)) begin
            w_irq_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RST_HOLD;
            r_cnt        <= c_RST_LOAD;
            r_rst_pend   <= 1'b0;
            r_pop_ack    <= 1'b0;
            r_pop_empty  <= 1'b0;
            r_rd_en      <= 1'b0;
            r_fifo_rst_n <= 1'b0;
            r_irq        <= 1'b0;
            r_underflow  <= 1'b0;
            r_hwm        <= '0;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rst_pend   <= w_rst_pend_nxt;
            // Outputs decode the next state so they are registered yet aligned
            r_pop_ack    <= (w_state_nxt == S_ACK);
            r_pop_empty  <= w_pop_empty_nxt;
            r_rd_en      <= (w_state_nxt == S_POP);
            r_fifo_rst_n <= (w_state_nxt != S_RST_HOLD);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_irq        <= w_irq_nxt;

            if (w_uflow_set) begin
                r_underflow <= 1'b1;
            end else if (clr_flags) begin
                r_underflow <= 1'b0;
            end

            // On clear the current occupancy is the first sample of the new window
            if (w_hwm_clr) begin
                r_hwm <= '0;
            end else if (clr_flags || (bus.fifo_numel > r_hwm)) begin
                r_hwm <= bus.fifo_numel;
            end
        end
    end

    assign bus.pop_ack    = r_pop_ack;
    assign bus.pop_empty  = r_pop_empty;
    assign bus.fifo_rd_en = r_rd_en;
    assign bus.fifo_rst_n = r_fifo_rst_n;
    assign irq            = r_irq;
    assign underflow      = r_underflow;
    assign hwm            = r_hwm;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fifo_readout_ctrl.sv
// ============================================================================
//  Module   : tb_fifo_readout_ctrl
//  Purpose  : Self-checking bench for fifo_readout_ctrl with a pop scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_readout_ctrl;

    localparam int AWIDTH     = 12;
    localparam int RST_CYCLES = 4;
    localparam int RD_LAT     = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AWIDTH-1:0] a_th, d_th, hwm;
    logic              sw_fifo_rst, clr_flags, irq, underflow, busy;

    always #5 clk = ~clk;

    fifo_readout_if #(.AWIDTH(AWIDTH)) bus ();

    fifo_readout_ctrl #(
        .AWIDTH     (AWIDTH),
        .RST_CYCLES (RST_CYCLES),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .irq_assert_thresh   (a_th),
        .irq_deassert_thresh (d_th),
        .sw_fifo_rst         (sw_fifo_rst),
        .clr_flags           (clr_flags),
        .irq                 (irq),
        .underflow           (underflow),
        .hwm                 (hwm),
        .busy                (busy)
    );

    typedef struct {
        logic empty;
        int   ack_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   last_rd = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pop_ack is matched against the oldest expected pop
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                last_rd = cyc;
            end
            if (bus.pop_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("ack_empty", int'(bus.pop_empty), int'(m_e.empty));
                    chk("ack_cycle", cyc, m_e.ack_cyc);
                    chk("rd_per_ack", rd_cnt, m_e.empty ? 0 : 1);
                    if (!m_e.empty) chk("rd_to_ack", cyc - last_rd, RD_LAT);
                end
                rd_cnt = 0;
            end
        end
    end

    // Called at a negedge; request is sampled at the next posedge
    task automatic do_pop();
        exp_t e;
        bit   got = 0;
        e.empty   = (bus.fifo_numel == '0);
        e.ack_cyc = cyc + 1 + (e.empty ? 0 : RD_LAT);
        exp_q.push_back(e);
        bus.pop_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pop_ack) begin
                got = 1;
                break;
            end
        end
        bus.pop_req = 1'b0;
        if (!got) begin
            chk("pop_timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Called at the first negedge where fifo_rst_n is low
    task automatic measure_rst(input string name);
        int low = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fifo_rst_n !== 1'b0) break;
            low++;
            @(negedge clk);
        end
        chk(name, low, RST_CYCLES);
    endtask

    task automatic set_numel(input int v);
        bus.fifo_numel = AWIDTH'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.pop_req = 1'b0;
        set_numel(0);
        a_th        = 12'd789;
        d_th        = 12'd11;
        sw_fifo_rst = 1'b0;
        clr_flags   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("por_fifo_rst_n", int'(bus.fifo_rst_n), 0);
        chk("por_busy", int'(busy), 1);
        chk("por_irq", int'(irq), 0);
        chk("por_hwm", int'(hwm), 0);
        chk("por_underflow", int'(underflow), 0);
        chk("por_pop_ack", int'(bus.pop_ack), 0);
        chk("por_rd_en", int'(bus.fifo_rd_en), 0);
        rst_n = 1'b1;
        measure_rst("por_rst_len");
        chk("por_done_busy", int'(busy), 0);
        chk("por_done_irq", int'(irq), 0);
        chk("por_done_hwm", int'(hwm), 0);

        // IRQ hysteresis 11/789
        for (int v = 780; v <= 789; v++) begin
            set_numel(v);
            @(negedge clk);
            chk("irq_ramp_up", int'(irq), (v >= 789) ? 1 : 0);
        end
        for (int v = 20; v >= 5; v--) begin
            set_numel(v);
            @(negedge clk);
            chk("irq_ramp_down", int'(irq), (v > 11) ? 1 : 0);
        end

        // Misconfigured thresholds force irq low
        set_numel(12'hFFF);
        @(negedge clk);
        chk("irq_reassert", int'(irq), 1);
        a_th = 12'h2AA; d_th = 12'h2AA;
        @(negedge clk);
        chk("irq_equal_thresh", int'(irq), 0);
        a_th = 12'd789; d_th = 12'd11;
        @(negedge clk);
        chk("irq_restore_1", int'(irq), 1);
        a_th = 12'hFFF; d_th = 12'hFFF;
        @(negedge clk);
        chk("irq_fff_thresh", int'(irq), 0);
        a_th = 12'd789; d_th = 12'd11;
        @(negedge clk);
        chk("irq_restore_2", int'(irq), 1);
        a_th = 12'd0;
        @(negedge clk);
        chk("irq_assert_zero", int'(irq), 0);
        a_th = 12'd789;
        set_numel(0);
        @(negedge clk);
        chk("irq_low_numel", int'(irq), 0);

        // High-water mark and clear
        set_numel(3);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("hwm_clr_to_3", int'(hwm), 3);
        set_numel(40);
        @(negedge clk);
        chk("hwm_40", int'(hwm), 40);
        set_numel(7);
        @(negedge clk);
        chk("hwm_hold_40", int'(hwm), 40);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("hwm_clr_to_7", int'(hwm), 7);
        @(negedge clk);
        chk("hwm_stay_7", int'(hwm), 7);

        // Eight non-empty pops
        set_numel(5);
        repeat (8) do_pop();
        chk("no_underflow", int'(underflow), 0);

        // Empty pop, sticky underflow
        set_numel(0);
        do_pop();
        chk("underflow_set", int'(underflow), 1);
        repeat (5) @(negedge clk);
        chk("underflow_sticky", int'(underflow), 1);

        // sw_fifo_rst coincident with pop_req in IDLE
        set_numel(5);
        bus.pop_req = 1'b1;
        sw_fifo_rst = 1'b1;
        @(negedge clk);
        bus.pop_req = 1'b0;
        sw_fifo_rst = 1'b0;
        chk("swrst_idle_no_rd", int'(bus.fifo_rd_en), 0);
        measure_rst("swrst_idle_len");
        chk("swrst_idle_rd_cnt", rd_cnt, 0);
        chk("underflow_survives_rst", int'(underflow), 1);

        // sw_fifo_rst while a pop is in flight
        set_numel(9);
        m_e.empty   = 1'b0;
        m_e.ack_cyc = cyc + 1 + RD_LAT;
        exp_q.push_back(m_e);
        bus.pop_req = 1'b1;
        @(negedge clk);
        chk("pend_rd_en", int'(bus.fifo_rd_en), 1);
        sw_fifo_rst = 1'b1;
        @(negedge clk);
        sw_fifo_rst = 1'b0;
        bus.pop_req = 1'b0;
        chk("pend_ack_first", int'(bus.pop_ack), 1);
        chk("pend_rst_after_ack", int'(bus.fifo_rst_n), 1);
        set_numel(0);
        @(negedge clk);
        measure_rst("swrst_pend_len");
        chk("pend_hwm_cleared", int'(hwm), 0);
        chk("pend_busy", int'(busy), 0);
        chk("pend_queue_empty", exp_q.size(), 0);

        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("underflow_cleared", int'(underflow), 0);

        // Asynchronous reset mid-pop drops the pop
        set_numel(5);
        bus.pop_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_fifo_rst_n", int'(bus.fifo_rst_n), 0);
        chk("arst_rd_en", int'(bus.fifo_rd_en), 0);
        chk("arst_busy", int'(busy), 1);
        bus.pop_req = 1'b0;
        @(negedge clk);
        rd_cnt = 0;
        rst_n = 1'b1;
        measure_rst("arst_rst_len");
        repeat (3) @(negedge clk);
        chk("arst_no_ack", exp_q.size(), 0);
        chk("arst_idle_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
